path_delay_meter: RTL and testbench

Launch-and-capture controller that drives the input of an inverter delay path and times its output. Each trial toggles the launch line, synchronises the path output, and counts clock cycles until the expected level arrives. It accumulates the result over a programmable number of trials. Sits directly upstream and downstream of the delay chain: its `pathInput` feeds the chain head, and the chain tail returns on `pathResult`.

---
 rtl/path_delay_meter.sv | 140 ++++++++++++++
 tb/tb_path_delay_meter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/path_delay_meter.sv
// path_delay_meter: launch/capture timer for an external delay path; define PATH_DELAY_MINMAX_EN to build min/max tracking
module path_delay_meter #(
    parameter int CNT_W       = 16,
    parameter int TRIALS_W    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000,
    parameter int GAP_CYCLES  = 8,
    parameter bit PATH_INVERT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TRIALS_W-1:0]       trials,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [CNT_W+TRIALS_W-1:0] sum_cycles,
    output logic [CNT_W-1:0]          min_cycles,
    output logic [CNT_W-1:0]          max_cycles,
    output logic [TRIALS_W-1:0]       trials_done,
    output logic                      pathInput,
    input  logic                      pathResult
);
    localparam int SUM_W = CNT_W + TRIALS_W;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, GAP, WAIT, RECORD, DONE} state_t;
    state_t                 state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TRIALS_W-1:0]    trials_q, trials_d, tdone_q, tdone_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic                   err_q, err_d, path_q, path_d, match;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
`ifdef PATH_DELAY_MINMAX_EN
    logic [CNT_W-1:0]       min_q, min_d, max_q, max_d;
    assign min_cycles = min_q;
    assign max_cycles = max_q;
`else
    assign min_cycles = '0;
    assign max_cycles = '0;
`endif
    assign match       = sync_q[SYNC_STAGES-1] == (path_q ^ PATH_INVERT);
    assign busy        = state_q inside {GAP, WAIT, RECORD};
    assign done        = state_q == DONE;
    assign timeout_err = err_q;
    assign sum_cycles  = sum_q;
    assign trials_done = tdone_q;
    assign pathInput   = path_q;
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        trials_d = trials_q;
        tdone_d  = tdone_q;
        sum_d    = sum_q;
        err_d    = err_q;
        path_d   = path_q;
        sync_d   = {sync_q[SYNC_STAGES-2:0], pathResult};
`ifdef PATH_DELAY_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                trials_d = trials;
                tdone_d  = '0;
                sum_d    = '0;
                err_d    = 1'b0;
                gap_d    = '0;
`ifdef PATH_DELAY_MINMAX_EN
                min_d    = '1;
                max_d    = '0;
`endif
                state_d  = (trials != '0) ? GAP : DONE;
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    path_d  = ~path_q;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // a match in the timeout cycle still records the trial
                if (match) state_d = RECORD;
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RECORD: begin
                sum_d   = sum_q + SUM_W'(cnt_q);
                tdone_d = tdone_q + 1'b1;
                gap_d   = '0;
`ifdef PATH_DELAY_MINMAX_EN
                min_d   = (cnt_q < min_q) ? cnt_q : min_q;
                max_d   = (cnt_q > max_q) ? cnt_q : max_q;
`endif
                state_d = (tdone_d == trials_q) ? DONE : GAP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            cnt_q    <= '0;
            trials_q <= '0;
            tdone_q  <= '0;
            sum_q    <= '0;
            err_q    <= 1'b0;
            path_q   <= 1'b0;
            sync_q   <= '0;
`ifdef PATH_DELAY_MINMAX_EN
            min_q    <= '1;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            trials_q <= trials_d;
            tdone_q  <= tdone_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
            path_q   <= path_d;
            sync_q   <= sync_d;
`ifdef PATH_DELAY_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end
endmodule

// File: tb/tb_path_delay_meter.sv
// tb_path_delay_meter: scoreboard bench driving a modelled delay path with asymmetric rise/fall delays
module tb_path_delay_meter;
    localparam int S  = 3;
    localparam int TO = 20;
    localparam int G  = 4;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0]  trials = '0;
    logic        busy, done, timeout_err, path_input, path_result;
    logic [23:0] sum_cycles;
    logic [15:0] min_cycles, max_cycles;
    logic [7:0]  trials_done;
    logic [31:0] hist = '0;
    logic [32:0] hx;
    logic [4:0]  dr = '0, df = '0;
    bit          stuck = 1'b0;
    bit          lvl = 1'b0;
    int          checks = 0, errors = 0, cyc = 0;
    typedef struct {int sum; int mn; int mx; int td; int err; int lvl; int lat; int t0;} exp_t;
    exp_t sb[$];

    path_delay_meter #(.CNT_W(16), .TRIALS_W(8), .SYNC_STAGES(S), .TIMEOUT(TO),
                       .GAP_CYCLES(G), .PATH_INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .trials(trials), .busy(busy), .done(done),
        .timeout_err(timeout_err), .sum_cycles(sum_cycles), .min_cycles(min_cycles),
        .max_cycles(max_cycles), .trials_done(trials_done), .pathInput(path_input),
        .pathResult(path_result));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // output follows the input after dr cycles on a rising launch, df on a falling one
    always @(posedge clk) hist <= {hist[30:0], path_input};
    assign hx = {hist, path_input};
    always_comb path_result = stuck ? 1'b0 : hx[path_input ? dr : df];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset();
`ifdef PATH_DELAY_MINMAX_EN
        check("rst_min", 32'(min_cycles), 32'hFFFF);
`else
        check("rst_min", 32'(min_cycles), 0);
`endif
        check("rst_max", 32'(max_cycles), 0);
        check("rst_path", 32'(path_input), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(timeout_err), 0);
        check("rst_sum", 32'(sum_cycles), 0);
        check("rst_tdone", 32'(trials_done), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) check("spurious_done", 32'(done), 0);
            else begin
                e = sb.pop_front();
                check("sum", 32'(sum_cycles), e.sum);
                check("min", 32'(min_cycles), e.mn);
                check("max", 32'(max_cycles), e.mx);
                check("trials_done", 32'(trials_done), e.td);
                check("timeout_err", 32'(timeout_err), e.err);
                check("path_level", 32'(path_input), e.lvl);
                check("busy_at_done", 32'(busy), 0);
                check("done_latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic run(int n, bit mid_start);
        exp_t e;
        int   c, w;
        e.sum = 0; e.td = 0; e.err = 0; e.lat = 0; e.mx = 0;
`ifdef PATH_DELAY_MINMAX_EN
        e.mn = 'hFFFF;
`else
        e.mn = 0;
`endif
        for (int k = 0; k < n && e.err == 0; k++) begin
            lvl = ~lvl;
            c = stuck ? (lvl ? TO : 0) : S + int'(lvl ? dr : df);
            if (c >= TO) begin
                e.err = 1;
                e.lat += G + TO;
            end else begin
                e.sum += c;
                e.td++;
                e.lat += G + c + 2;
`ifdef PATH_DELAY_MINMAX_EN
                if (c < e.mn) e.mn = c;
                if (c > e.mx) e.mx = c;
`endif
            end
        end
        e.lvl = int'(lvl);
        @(negedge clk);
        start = 1'b1;
        trials = 8'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        trials = 8'($urandom);
        e.t0 = cyc;
        sb.push_back(e);
        if (n != 0) begin
            @(negedge clk);
            check("busy_run", 32'(busy), 1);
            if (mid_start) begin
                start = 1'b1;
                trials = 8'($urandom_range(1, 255));
                @(negedge clk);
                start = 1'b0;
            end
        end
        w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            check("done_wait", 32'(sb.size()), 0);
            sb.delete();
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        stuck = 1'b1;
        run(3, 1'b0);
        stuck = 1'b0;
        repeat (40) @(negedge clk);
        dr = 5'd0; df = 5'd0; run(4, 1'b0);
        dr = 5'd5; df = 5'd5; run(3, 1'b1);
        run(0, 1'b0);
        dr = 5'd1; df = 5'd4; run(6, 1'b0);
        dr = 5'd16; df = 5'd16; run(2, 1'b0);
        dr = 5'd17; df = 5'd17; run(2, 1'b0);
        dr = 5'd2; df = 5'd2;
        @(negedge clk);
        start = 1'b1;
        trials = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        lvl = 1'b0;
        repeat (40) @(negedge clk);
        run(3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            dr = 5'($urandom_range(0, 8));
            df = 5'($urandom_range(0, 8));
            run($urandom_range(0, 12), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
